// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Single-port data memory that answers processor load/store
//            requests after a fixed number of wait states.
// Revision : 1.0
// ============================================================================
module dmem_responder #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic        memread,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        ready,
    output logic        err
);

    localparam int         AW     = $clog2(DEPTH);
    localparam logic [3:0] C_WAIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_cnt;
    logic [3:0]    w_cnt_nxt;

    logic [AW-1:0] r_idx;
    logic          r_mis;
    logic          r_wr;
    logic          r_both;
    logic [31:0]   r_wdata;

    logic [31:0]   r_mem [DEPTH];
    logic [31:0]   r_rdata;
    logic          r_ready;
    logic          r_err;

    logic          w_req;
    logic          w_enter_resp;
    logic          w_from_idle;
    logic [AW-1:0] w_cur_idx;
    logic          w_cur_mis;
    logic          w_cur_wr;
    logic          w_cur_both;
    logic [31:0]   w_cur_wdata;
    logic          w_unused;

    assign w_req       = memread | memwrite;
    assign w_from_idle = (r_state == ST_IDLE);

    // With zero wait states RESP is entered straight from IDLE, so the live
    // request fields are used; otherwise the latched copy is authoritative.
    assign w_cur_idx   = w_from_idle ? dataadr[AW+1:2]          : r_idx;
    assign w_cur_mis   = w_from_idle ? (dataadr[1:0] != 2'b00)  : r_mis;
    assign w_cur_wr    = w_from_idle ? memwrite                 : r_wr;
    assign w_cur_both  = w_from_idle ? (memwrite & memread)     : r_both;
    assign w_cur_wdata = w_from_idle ? writedata                : r_wdata;

    assign w_unused = &{1'b0, dataadr[31:AW+2]};

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_enter_resp = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    if (C_WAIT == 4'd0) begin
                        w_state_nxt  = ST_RESP;
                        w_cnt_nxt    = 4'd0;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_nxt = ST_BUSY;
                        w_cnt_nxt   = C_WAIT;
                    end
                end
            end
            ST_BUSY: begin
                if (r_cnt <= 4'd1) begin
                    w_state_nxt  = ST_RESP;
                    w_cnt_nxt    = 4'd0;
                    w_enter_resp = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_ready <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ready <= w_enter_resp;
            if (w_enter_resp && !w_cur_wr && !w_cur_mis) begin
                r_rdata <= r_mem[w_cur_idx];
            end else begin
                r_rdata <= '0;
            end
            if (w_enter_resp && (w_cur_mis || w_cur_both)) begin
                r_err <= 1'b1;
            end
        end
    end

    // Request capture; these fields are only consumed while BUSY.
    always_ff @(posedge clk) begin
        if (w_from_idle && w_req) begin
            r_idx   <= dataadr[AW+1:2];
            r_mis   <= (dataadr[1:0] != 2'b00);
            r_wr    <= memwrite;
            r_both  <= memwrite & memread;
            r_wdata <= writedata;
        end
    end

    // Memory contents survive reset; a write only lands on a normal RESP entry.
    always_ff @(posedge clk) begin
        if (!reset && w_enter_resp && w_cur_wr && !w_cur_mis) begin
            r_mem[w_cur_idx] <= w_cur_wdata;
        end
    end

    assign readdata = r_rdata;
    assign ready    = r_ready;
    assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Self-checking bench for dmem_responder (WAIT=2 and WAIT=0 units).
// Revision : 1.0
// ============================================================================
module tb_dmem_responder;

    localparam int DEPTH = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst = 2'b11;
    logic [1:0]       mr  = 2'b00;
    logic [1:0]       mw  = 2'b00;
    logic [1:0][31:0] da  = '0;
    logic [1:0][31:0] wdv = '0;

    logic [31:0] rdat0, rdat1;
    logic        rdy0, rdy1, erro0, erro1;

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) u_dut0 (
        .clk(clk), .reset(rst[0]), .memwrite(mw[0]), .memread(mr[0]),
        .dataadr(da[0]), .writedata(wdv[0]),
        .readdata(rdat0), .ready(rdy0), .err(erro0)
    );

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut1 (
        .clk(clk), .reset(rst[1]), .memwrite(mw[1]), .memread(mr[1]),
        .dataadr(da[1]), .writedata(wdv[1]),
        .readdata(rdat1), .ready(rdy1), .err(erro1)
    );

    int          n_chk = 0;
    int          n_err = 0;
    int          c_wait [2];
    logic [31:0] m_mem [2][DEPTH];
    bit          m_kn  [2][DEPTH];
    bit          m_err [2];

    typedef struct {
        int          sel;
        bit          rd;
        bit          wr;
        logic [31:0] adr;
        logic [31:0] wd;
        bit          chk_rd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl [$];

    function automatic logic [31:0] get_rdat(input int s);
        return (s == 0) ? rdat0 : rdat1;
    endfunction
    function automatic logic get_rdy(input int s);
        return (s == 0) ? rdy0 : rdy1;
    endfunction
    function automatic logic get_err(input int s);
        return (s == 0) ? erro0 : erro1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One complete request; the reference model predicts memory, err and latency.
    task automatic run_txn(input int s, input bit rd, input bit wr,
                           input logic [31:0] adr, input logic [31:0] wd,
                           output logic [31:0] got_rd, output logic got_err);
        int          idx;
        bit          mis;
        bit          pre_err;
        bit          done;
        bit          exp_known;
        int          lat;
        logic [31:0] exp_rd;
        idx       = int'((adr >> 2) % DEPTH);
        mis       = (adr % 4) != 0;
        pre_err   = m_err[s];
        exp_known = 1'b0;
        exp_rd    = 32'd0;
        if (wr) begin
            if (!mis) begin
                m_mem[s][idx] = wd;
                m_kn[s][idx]  = 1'b1;
            end
            exp_known = mis;
        end else if (mis) begin
            exp_known = 1'b1;
        end else if (m_kn[s][idx]) begin
            exp_known = 1'b1;
            exp_rd    = m_mem[s][idx];
        end
        if (mis || (rd && wr)) m_err[s] = 1'b1;

        @(negedge clk);
        mr[s] = rd; mw[s] = wr; da[s] = adr; wdv[s] = wd;
        @(posedge clk);
        done = 1'b0; lat = 0; got_rd = 'x; got_err = 1'bx;
        for (int k = 0; k < 40 && !done; k++) begin
            #1;
            if (get_rdy(s)) begin
                done    = 1'b1;
                lat     = k + 1;
                got_rd  = get_rdat(s);
                got_err = get_err(s);
            end else begin
                chk($sformatf("rdata_zero_u%0d", s), get_rdat(s), 32'd0);
                chk($sformatf("err_hold_u%0d", s), {31'd0, get_err(s)}, {31'd0, pre_err});
                @(negedge clk);
                da[s]  = $urandom;
                wdv[s] = $urandom;
                @(posedge clk);
            end
        end
        chk($sformatf("latency_u%0d", s), lat, c_wait[s] + 1);
        if (done) begin
            chk($sformatf("err_resp_u%0d", s), {31'd0, got_err}, {31'd0, m_err[s]});
            if (exp_known) chk($sformatf("rdata_u%0d_a%0h", s, adr), got_rd, exp_rd);
        end
        @(negedge clk);
        mr[s] = 1'b0; mw[s] = 1'b0;
        @(posedge clk);
        #1 chk($sformatf("ready_one_cycle_u%0d", s), {31'd0, get_rdy(s)}, 32'd0);
    endtask

    task automatic do_reset(input int s);
        @(negedge clk);
        rst[s] = 1'b1; mr[s] = 1'b0; mw[s] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst[s]   = 1'b0;
        m_err[s] = 1'b0;
        chk($sformatf("rst_ready_u%0d", s), {31'd0, get_rdy(s)}, 32'd0);
        chk($sformatf("rst_err_u%0d", s), {31'd0, get_err(s)}, 32'd0);
        chk($sformatf("rst_rdata_u%0d", s), get_rdat(s), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got_rd;
        logic        got_err;
        logic [31:0] adr;
        int          s;
        int          kind;

        c_wait[0] = 2;
        c_wait[1] = 0;
        for (int u = 0; u < 2; u++) begin
            m_err[u] = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[u][i] = 32'd0;
                m_kn[u][i]  = 1'b0;
            end
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 2'b00;
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("init_ready_u%0d", u), {31'd0, get_rdy(u)}, 32'd0);
            chk($sformatf("init_err_u%0d", u), {31'd0, get_err(u)}, 32'd0);
            chk($sformatf("init_rdata_u%0d", u), get_rdat(u), 32'd0);
        end

        //            sel rd wr adr           wd            chk exp_rd        err
        tbl.push_back('{0, 0, 1, 32'd84,       32'd1,        0, 32'd0,        1'b0});
        tbl.push_back('{0, 1, 0, 32'd84,       32'd0,        1, 32'd1,        1'b0});
        tbl.push_back('{1, 0, 1, 32'd80,       32'd7,        0, 32'd0,        1'b0});
        tbl.push_back('{1, 1, 0, 32'd80,       32'd0,        1, 32'd7,        1'b0});
        tbl.push_back('{0, 0, 1, 32'd340,      32'hDEADBEEF, 0, 32'd0,        1'b0});
        tbl.push_back('{0, 1, 0, 32'd84,       32'd0,        1, 32'hDEADBEEF, 1'b0});
        tbl.push_back('{0, 0, 1, 32'h55,       32'd5,        1, 32'd0,        1'b1});
        tbl.push_back('{0, 1, 0, 32'h54,       32'd0,        1, 32'hDEADBEEF, 1'b1});
        tbl.push_back('{1, 1, 1, 32'd8,        32'd9,        0, 32'd0,        1'b1});
        tbl.push_back('{1, 1, 0, 32'd8,        32'd0,        1, 32'd9,        1'b1});

        foreach (tbl[i]) begin
            run_txn(tbl[i].sel, tbl[i].rd, tbl[i].wr, tbl[i].adr, tbl[i].wd, got_rd, got_err);
            chk($sformatf("tbl%0d_err", i), {31'd0, got_err}, {31'd0, tbl[i].exp_err});
            if (tbl[i].chk_rd) chk($sformatf("tbl%0d_rdata", i), got_rd, tbl[i].exp_rd);
        end

        // Reset during BUSY: the pending write of 4 must be lost.
        run_txn(0, 0, 1, 32'd12, 32'd3, got_rd, got_err);
        @(negedge clk);
        mw[0] = 1'b1; da[0] = 32'd12; wdv[0] = 32'd4;
        @(posedge clk);
        #1 chk("abort_ready_busy", {31'd0, rdy0}, 32'd0);
        @(negedge clk);
        rst[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1 chk($sformatf("abort_ready_rst%0d", k), {31'd0, rdy0}, 32'd0);
            @(negedge clk);
            mw[0] = 1'b0;
        end
        rst[0]   = 1'b0;
        m_err[0] = 1'b0;
        chk("abort_err_cleared", {31'd0, erro0}, 32'd0);
        m_mem[0][3] = 32'd3;
        run_txn(0, 1, 0, 32'd12, 32'd0, got_rd, got_err);
        chk("abort_read_old", got_rd, 32'd3);
        chk("abort_read_err", {31'd0, got_err}, 32'd0);

        for (int n = 0; n < 160; n++) begin
            if (n % 40 == 0) do_reset(n / 40 % 2);
            s    = int'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 19));
            adr  = ($urandom_range(0, 15) << 2) | ($urandom_range(0, 3) << 8);
            if ($urandom_range(0, 9) == 0) adr = adr | $urandom_range(1, 3);
            if (kind < 9)
                run_txn(s, 1'b1, 1'b0, adr, 32'd0, got_rd, got_err);
            else if (kind < 19)
                run_txn(s, 1'b0, 1'b1, adr, $urandom, got_rd, got_err);
            else
                run_txn(s, 1'b1, 1'b1, adr, $urandom, got_rd, got_err);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, meaning the number of 32-bit data words; it is a power of two.
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, range 0-15, meaning the number of wait states inserted before each response.
REQ-003 The block SHALL have port clk  input  1  system clock; the block uses the rising edge only.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port memwrite  input  1  write request from the processor, held high until ready.
REQ-006 The block SHALL have port memread  input  1  read request from the processor, held high until ready.
REQ-007 The block SHALL have port dataadr  input  32  byte address of the request.
REQ-008 The block SHALL have port writedata  input  32  store data, valid with memwrite.
REQ-009 The block SHALL have port readdata  output  32  load data, valid only while ready=1.
REQ-010 The block SHALL have port ready  output  1  one-cycle completion pulse.
REQ-011 The block SHALL have port err  output  1  sticky error flag.

Function
REQ-012 The block SHALL implement a state machine with states IDLE, BUSY and RESP.
REQ-013 The IDLE-to-BUSY transition SHALL occur at the first rising edge in IDLE at which memread|memwrite=1.
- At that edge the block latches dataadr, writedata and the request type.
- It loads the wait counter with WAIT_CYCLES.
- If WAIT_CYCLES=0, the block goes directly to RESP.
REQ-014 In BUSY, the wait counter SHALL decrement once per cycle.
- The block goes to RESP at the edge where the counter equals 1.
- Request latency is WAIT_CYCLES+1 edges from the sampling edge to ready=1.
REQ-015 RESP SHALL last exactly one cycle with ready=1, then return to IDLE unconditionally.
REQ-016 Request inputs sampled during BUSY and RESP SHALL be ignored, including changes to dataadr or writedata.
- The requester deasserts its request in the cycle after ready.
- A request still high in IDLE after RESP starts a new transaction.
REQ-017 A write SHALL update the addressed word at the edge entering RESP, using the latched address and data.
REQ-018 A read SHALL drive readdata from the latched address during RESP.
- readdata equals 0 in every cycle where ready=0.
REQ-019 The word index SHALL be latched dataadr[log2(DEPTH)+1:2].
- Higher address bits are ignored, so addresses alias modulo DEPTH*4 bytes.
REQ-020 A latched address with bits [1:0] not equal to 0 SHALL NOT modify memory.
- readdata returns 0.
- ready still pulses with normal latency.
- err is set.
REQ-021 When memread and memwrite are both high at the sampling edge, the block SHALL perform the write, treat the transaction as a write, and set err.
REQ-022 err SHALL stay at 1 until reset once set, and SHALL change only at the edge entering RESP.
REQ-023 A read-after-write to the same address in consecutive transactions SHALL return the newly written data.

Reset
REQ-024 While reset=1 at a rising edge, the block SHALL set state=IDLE, ready=0, readdata=0, err=0 and wait counter=0, overriding any transaction in progress.
REQ-025 Reset SHALL NOT clear memory contents.
- A write aborted in BUSY does not modify memory.
- Unwritten words hold an undefined value; no test checks them.
REQ-026 The first request SHALL be sampled no earlier than the first edge with reset=0.

Verification
REQ-027 The bench SHALL cover the baseline write-then-read case.
- Stimulus: WAIT_CYCLES=2, memwrite with dataadr=84, writedata=1; then memread with dataadr=84.
- Response: ready=1 exactly 3 edges after each sampling edge; the read returns readdata=1, err=0.
REQ-028 The bench SHALL cover zero-wait operation.
- Stimulus: WAIT_CYCLES=0, write 7 to address 80, then read address 80.
- Response: ready=1 in the cycle after each sampling edge; readdata=7.
REQ-029 The bench SHALL cover address aliasing.
- Stimulus: DEPTH=64, write 0xDEADBEEF to address 84+256=340, then read address 84.
- Response: readdata=0xDEADBEEF.
REQ-030 The bench SHALL cover a misaligned write.
- Stimulus: write 5 to address 0x55, then read address 0x54.
- Response: first ready pulse has readdata=0; err=1 from that cycle onward; the read returns the prior contents of word 0x54.
REQ-031 The bench SHALL cover simultaneous read and write.
- Stimulus: memread=memwrite=1, dataadr=8, writedata=9; then read address 8.
- Response: the read returns 9; err=1.
REQ-032 The bench SHALL cover reset mid-transaction.
- Stimulus: address 12 holds 3; start a write of 4 to address 12 with WAIT_CYCLES=2; assert reset during BUSY; then read address 12.
- Response: no ready pulse during reset; err=0; the read returns 3.
